// File: rtl/action_input_conditioner_pkg.sv
// Shared action codes, FSM encodings and press-vector type for the player input front end.
// The action codes are also consumed by the player logic.
package action_input_conditioner_pkg;

    localparam int unsigned ACT_W     = 3;
    localparam int unsigned DEB_CNT_W = 20;

    typedef logic [ACT_W-1:0] action_t;

    localparam action_t ACT_IDLE   = 3'd0;
    localparam action_t ACT_LEFT   = 3'd1;
    localparam action_t ACT_RIGHT  = 3'd2;
    localparam action_t ACT_ATTACK = 3'd3;
    localparam action_t ACT_DEFEND = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    typedef struct packed {
        logic defend;
        logic attack;
        logic left;
        logic right;
    } btn_vec_t;

    // Priority defend > attack > left > right; a blocked attack falls through to lower priorities.
    function automatic action_t encode_press(input btn_vec_t p, input logic attack_blocked);
        action_t code;
        code = ACT_IDLE;
        if (p.defend) begin
            code = ACT_DEFEND;
        end else if (p.attack && !attack_blocked) begin
            code = ACT_ATTACK;
        end else if (p.left) begin
            code = ACT_LEFT;
        end else if (p.right) begin
            code = ACT_RIGHT;
        end
        return code;
    endfunction

endpackage

// File: rtl/action_input_conditioner_button_debouncer.sv
// One raw button: 2-flop synchroniser, stability counter and a registered rising-edge press pulse.
module button_debouncer
    import action_input_conditioner_pkg::*;
#(
    parameter logic [DEB_CNT_W-1:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic                 sync_q1;
    logic                 sync_q2;
    logic                 level_q;
    logic [DEB_CNT_W-1:0] cnt_q;
    logic                 settle_c;

    assign settle_c = (cnt_q == DEBOUNCE_CYCLES - DEB_CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            // The pulse is issued on the same edge the debounced level rises.
            press   <= sync_q2 & ~level_q & settle_c;
            if (sync_q2 != level_q) begin
                if (settle_c) begin
                    level_q <= sync_q2;
                    cnt_q   <= '0;
                end else begin
                    cnt_q   <= cnt_q + DEB_CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/action_input_conditioner.sv
// Per-player button front end: debounced presses are priority-encoded, then issued for
// exactly one game tick, with attacks rate-limited by a tick-based cooldown.
module action_input_conditioner #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter int unsigned ATTACK_COOLDOWN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       btn_defend,
    output logic [2:0] action,
    output logic       cooldown_active
);
    import action_input_conditioner_pkg::*;

    localparam int unsigned CD_W = (ATTACK_COOLDOWN < 1) ? 1 : $clog2(ATTACK_COOLDOWN + 1);

    btn_vec_t        presses;
    action_t         enc_c;
    state_t          state_q, state_n;
    action_t         pending_q, pending_n;
    action_t         action_n;
    logic [CD_W-1:0] cd_cnt_q, cd_cnt_n;
    logic            cd_active_n;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk(clk), .reset(reset), .btn(btn_left), .press(presses.left)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk(clk), .reset(reset), .btn(btn_right), .press(presses.right)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_attack (
        .clk(clk), .reset(reset), .btn(btn_attack), .press(presses.attack)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_defend (
        .clk(clk), .reset(reset), .btn(btn_defend), .press(presses.defend)
    );

    assign enc_c = encode_press(presses, cooldown_active);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            pending_q       <= ACT_IDLE;
            action          <= ACT_IDLE;
            cd_cnt_q        <= '0;
            cooldown_active <= 1'b0;
        end else begin
            state_q         <= state_n;
            pending_q       <= pending_n;
            action          <= action_n;
            cd_cnt_q        <= cd_cnt_n;
            cooldown_active <= cd_active_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        pending_n   = pending_q;
        action_n    = action;
        cd_cnt_n    = cd_cnt_q;
        cd_active_n = cooldown_active;

        if (tick && (cd_cnt_q != '0)) begin
            cd_cnt_n    = cd_cnt_q - CD_W'(1);
            cd_active_n = (cd_cnt_q != CD_W'(1));
        end

        case (state_q)
            ST_IDLE: begin
                if (enc_c != ACT_IDLE) begin
                    pending_n = enc_c;
                    state_n   = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (tick) begin
                    action_n  = pending_q;
                    pending_n = ACT_IDLE;
                    state_n   = ST_ISSUE;
                    // Issuing an attack reloads the cooldown, overriding any decrement.
                    if ((pending_q == ACT_ATTACK) && (ATTACK_COOLDOWN != 0)) begin
                        cd_cnt_n    = CD_W'(ATTACK_COOLDOWN);
                        cd_active_n = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (tick) begin
                    action_n = ACT_IDLE;
                    if (pending_q != ACT_IDLE) begin
                        state_n = ST_ARMED;
                    end else if (enc_c != ACT_IDLE) begin
                        pending_n = enc_c;
                        state_n   = ST_ARMED;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else if ((pending_q == ACT_IDLE) && (enc_c != ACT_IDLE)) begin
                    pending_n = enc_c;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_action_input_conditioner.sv
// Self-checking bench for action_input_conditioner with DEBOUNCE_CYCLES=4, ATTACK_COOLDOWN=3.
module tb_action_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_attack;
    logic       btn_defend;
    logic [2:0] action;
    logic       cooldown_active;

    int         checks     = 0;
    int         errors     = 0;
    int         issued_cnt = 0;
    int         cd_ticks   = 0;
    logic [2:0] prev_action = 3'd0;
    logic [2:0] exp_q[$];

    typedef struct {
        logic [3:0] btns;   // {defend, attack, left, right}
        logic [2:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    action_input_conditioner #(
        .DEBOUNCE_CYCLES(20'd4),
        .ATTACK_COOLDOWN(3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .tick            (tick),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .btn_attack      (btn_attack),
        .btn_defend      (btn_defend),
        .action          (action),
        .cooldown_active (cooldown_active)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // One clock: drive tick, advance, then watch for issued actions against the scoreboard.
    task automatic step(input logic t);
        logic [2:0] a0;
        logic       c0;
        tick = t;
        a0   = action;
        c0   = cooldown_active;
        @(posedge clk);
        #1;
        tick = 1'b0;
        if (t && c0) cd_ticks++;
        if (!reset) begin
            if (t && (a0 != 3'd0)) chk("one_tick_hold", int'(action), 0);
            if ((action != prev_action) && (action != 3'd0)) begin
                issued_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got %0d required none", action);
                end else begin
                    chk("issue_order", int'(action), int'(exp_q.pop_front()));
                end
            end
        end
        prev_action = action;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    // Release everything and run enough ticks to clear action, cooldown and debounce state.
    task automatic settle();
        {btn_defend, btn_attack, btn_left, btn_right} = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            wait_cycles(10);
            step(1'b1);
        end
        chk("settle_action", int'(action), 0);
        chk("settle_cooldown", int'(cooldown_active), 0);
    endtask

    initial begin
        vecs[0] = '{4'b0001, 3'd2, "right_only"};
        vecs[1] = '{4'b0010, 3'd1, "left_only"};
        vecs[2] = '{4'b0100, 3'd3, "attack_only"};
        vecs[3] = '{4'b1000, 3'd4, "defend_only"};
        vecs[4] = '{4'b0011, 3'd1, "left_over_right"};
        vecs[5] = '{4'b0110, 3'd3, "attack_over_left"};
        vecs[6] = '{4'b1100, 3'd4, "defend_over_attack"};
        vecs[7] = '{4'b1010, 3'd4, "defend_left_simul"};
        vecs[8] = '{4'b1111, 3'd4, "all_four"};
        vecs[9] = '{4'b0101, 3'd3, "attack_over_right"};

        reset = 1'b1;
        tick  = 1'b0;
        {btn_defend, btn_attack, btn_left, btn_right} = 4'b0000;
        step(1'b0);
        step(1'b0);
        reset = 1'b0;
        chk("reset_action", int'(action), 0);
        chk("reset_cooldown", int'(cooldown_active), 0);

        // Idle with random ticks
        for (int i = 0; i < 50; i++) begin
            step(1'($urandom_range(0, 1)));
            chk("idle_action", int'(action), 0);
            chk("idle_cooldown", int'(cooldown_active), 0);
        end

        // Table-driven single and simultaneous presses
        for (int i = 0; i < 10; i++) begin
            {btn_defend, btn_attack, btn_left, btn_right} = vecs[i].btns;
            exp_q.push_back(vecs[i].exp);
            wait_cycles(9);
            step(1'b1);
            chk(vecs[i].name, int'(action), int'(vecs[i].exp));
            settle();
        end
        chk("table_queue_drained", exp_q.size(), 0);

        // Minimum latency: press lands on the tick edge and must wait for the next tick
        btn_right = 1'b1;
        exp_q.push_back(3'd2);
        wait_cycles(6);
        step(1'b1);
        chk("press_on_tick_not_issued", int'(action), 0);
        step(1'b1);
        chk("latency_issue_next_tick", int'(action), 2);
        settle();

        // Attack bounce then hold: exactly one attack
        issued_cnt = 0;
        exp_q.push_back(3'd3);
        for (int i = 0; i < 80; i++) begin
            btn_attack = (i < 10) ? 1'(((i / 2) % 2) == 0) : 1'b1;
            step(1'(i % 20 == 19));
        end
        settle();
        chk("bounce_single_issue", issued_cnt, 1);

        // Cooldown: second attack dropped, right issued, cooldown over 3 ticks
        issued_cnt = 0;
        cd_ticks   = 0;
        btn_attack = 1'b1;
        exp_q.push_back(3'd3);
        wait_cycles(9);
        step(1'b1);
        chk("cd_attack_issued", int'(action), 3);
        chk("cd_active_set", int'(cooldown_active), 1);
        btn_attack = 1'b0;
        wait_cycles(9);
        step(1'b1);
        btn_attack = 1'b1;
        wait_cycles(9);
        step(1'b1);
        chk("cd_attack_dropped", int'(action), 0);
        chk("cd_still_active", int'(cooldown_active), 1);
        btn_right = 1'b1;
        exp_q.push_back(3'd2);
        wait_cycles(9);
        step(1'b1);
        chk("cd_right_issued", int'(action), 2);
        chk("cd_released", int'(cooldown_active), 0);
        chk("cd_tick_count", cd_ticks, 3);
        settle();
        chk("cd_issue_count", issued_cnt, 2);

        // Press during ISSUE: 001 -> 000 -> 010
        btn_left = 1'b1;
        exp_q.push_back(3'd1);
        wait_cycles(9);
        step(1'b1);
        chk("issue_left", int'(action), 1);
        btn_left  = 1'b0;
        btn_right = 1'b1;
        exp_q.push_back(3'd2);
        wait_cycles(9);
        step(1'b1);
        chk("issue_gap_idle", int'(action), 0);
        wait_cycles(9);
        step(1'b1);
        chk("issue_right_follows", int'(action), 2);
        settle();

        // Reset while ARMED with defend pending
        btn_defend = 1'b1;
        wait_cycles(9);
        reset      = 1'b1;
        btn_defend = 1'b0;
        step(1'b0);
        reset = 1'b0;
        chk("armed_reset_action", int'(action), 0);
        for (int k = 0; k < 3; k++) begin
            wait_cycles(10);
            step(1'b1);
            chk("armed_reset_no_defend", int'(action), 0);
        end

        // Reset during cooldown
        btn_attack = 1'b1;
        exp_q.push_back(3'd3);
        wait_cycles(9);
        step(1'b1);
        chk("pre_reset_cooldown", int'(cooldown_active), 1);
        reset      = 1'b1;
        btn_attack = 1'b0;
        step(1'b0);
        reset = 1'b0;
        chk("cd_reset_action", int'(action), 0);
        chk("cd_reset_cooldown", int'(cooldown_active), 0);
        settle();

        chk("final_queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
